// File: rtl/multicycle_alu.sv
// multicycle_alu: EX-stage ALU with iterative MULT/DIVU and a Start/Busy/Done handshake; optional ALU_OVERFLOW_EN adds the Overflow port
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Ctl,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Zero_Flag,
`ifdef ALU_OVERFLOW_EN
  output logic             Overflow,
`endif
  output logic             Error
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic is_div, accept, iter, last, valid, ovf_add, ovf_sub, slt;
  logic [WIDTH-1:0] b_r, wk_hi, wk_lo, wk_hi_n, wk_lo_n, sum, dif, res;
  logic [WIDTH:0] madd, shl, dsub;
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  always_comb begin
    accept = state == IDLE && Start;
    iter = ALU_Ctl == 4'b1000 || ALU_Ctl == 4'b1001;
    last = cnt == CW'(WIDTH - 1);
    state_n = state == IDLE ? (Start ? (iter ? EXEC : DONE) : IDLE) :
              state == EXEC ? (last ? DONE : EXEC) : IDLE;
  end
  always_comb begin
    Busy = state != IDLE;
    Done = state == DONE;
  end
  always_comb begin
    sum = A + B;
    dif = A - B;
    ovf_add = A[WIDTH-1] == B[WIDTH-1] && sum[WIDTH-1] != A[WIDTH-1];
    ovf_sub = A[WIDTH-1] != B[WIDTH-1] && dif[WIDTH-1] != A[WIDTH-1];
    slt = dif[WIDTH-1] ^ ovf_sub;
    valid = ALU_Ctl inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1000, 4'b1001};
    res = ALU_Ctl == 4'b0000 ? A & B :
          ALU_Ctl == 4'b0001 ? A | B :
          ALU_Ctl == 4'b0010 ? sum :
          ALU_Ctl == 4'b0110 ? dif :
          ALU_Ctl == 4'b0111 ? {{(WIDTH-1){1'b0}}, slt} :
          ALU_Ctl == 4'b1100 ? ~(A | B) : '0;
  end
  always_comb begin
    madd = {1'b0, wk_hi} + (wk_lo[0] ? {1'b0, b_r} : '0);
    shl = {wk_hi, wk_lo[WIDTH-1]};
    dsub = shl - {1'b0, b_r};
    wk_hi_n = is_div ? (dsub[WIDTH] ? shl[WIDTH-1:0] : dsub[WIDTH-1:0]) : madd[WIDTH:1];
    wk_lo_n = is_div ? {wk_lo[WIDTH-2:0], ~dsub[WIDTH]} : {madd[0], wk_lo[WIDTH-1:1]};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      Output <= '0;
      Hi <= '0;
      Lo <= '0;
      Zero_Flag <= 1'b1;
      Error <= 1'b0;
`ifdef ALU_OVERFLOW_EN
      Overflow <= 1'b0;
`endif
      cnt <= '0;
      is_div <= 1'b0;
      b_r <= '0;
      wk_hi <= '0;
      wk_lo <= '0;
    end else if (accept) begin
      b_r <= B;
      is_div <= ALU_Ctl[0];
      wk_hi <= '0;
      wk_lo <= A;
      cnt <= '0;
      if (!iter) begin
        Output <= res;
        Zero_Flag <= res == '0;
        Error <= !valid;
`ifdef ALU_OVERFLOW_EN
        Overflow <= ALU_Ctl == 4'b0010 ? ovf_add : ALU_Ctl == 4'b0110 ? ovf_sub : 1'b0;
`endif
      end
    end else if (state == EXEC) begin
      wk_hi <= wk_hi_n;
      wk_lo <= wk_lo_n;
      cnt <= cnt + 1'b1;
      if (last) begin
        Output <= wk_lo_n;
        Hi <= wk_hi_n;
        Lo <= wk_lo_n;
        Zero_Flag <= wk_lo_n == '0;
        Error <= 1'b0;
`ifdef ALU_OVERFLOW_EN
        Overflow <= 1'b0;
`endif
      end
    end
  end
`ifndef ALU_OVERFLOW_EN
  logic unused;
  assign unused = ovf_add;
`endif
endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: directed self-checking bench for multicycle_alu (WIDTH=32)
module tb_multicycle_alu;
  logic clk = 0, reset = 1, Start = 0;
  logic [31:0] A = 0, B = 0;
  logic [3:0] ALU_Ctl = 0;
  logic Busy, Done, Zero_Flag, Error;
  logic [31:0] Output, Hi, Lo;
`ifdef ALU_OVERFLOW_EN
  logic Overflow;
`endif
  int tests = 0, fails = 0, lat, busy_n, dones;
  always #5 clk = ~clk;
  multicycle_alu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .Start(Start), .A(A), .B(B), .ALU_Ctl(ALU_Ctl),
    .Busy(Busy), .Done(Done), .Output(Output), .Hi(Hi), .Lo(Lo),
    .Zero_Flag(Zero_Flag),
`ifdef ALU_OVERFLOW_EN
    .Overflow(Overflow),
`endif
    .Error(Error)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctl);
    @(posedge clk); #1;
    chk("idle_before", Busy, 0);
    A = a; B = b; ALU_Ctl = ctl; Start = 1;
    @(posedge clk); #1;
    Start = 0; A = ~a; B = ~b; ALU_Ctl = 4'b1111;
    lat = 1; busy_n = 0;
    while (!Done && lat < 100) begin
      if (Busy) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
    if (Busy) busy_n++;
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, Busy, 0);
    chk({tag, "_done"}, Done, 0);
    chk({tag, "_out"}, Output, 0);
    chk({tag, "_hi"}, Hi, 0);
    chk({tag, "_lo"}, Lo, 0);
    chk({tag, "_zero"}, Zero_Flag, 1);
    chk({tag, "_err"}, Error, 0);
`ifdef ALU_OVERFLOW_EN
    chk({tag, "_ovf"}, Overflow, 0);
`endif
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    reset = 0;
    run_op(32'h10696671, 32'h12345678, 4'b0000);
    chk("and", Output, 32'h10204670); chk("and_lat", lat, 1); chk("and_busy", busy_n, 1);
    chk("and_zero", Zero_Flag, 0);
    run_op(32'h10696671, 32'h12345678, 4'b0001);
    chk("or", Output, 32'h127D7679);
    run_op(32'h10696671, 32'h12345678, 4'b0010);
    chk("add", Output, 32'h229DBCE9); chk("add_lat", lat, 1);
    run_op(32'h10696671, 32'h12345678, 4'b0110);
    chk("sub", Output, 32'hFE350FF9);
    run_op(32'h10696671, 32'h12345678, 4'b0111);
    chk("slt", Output, 1);
    run_op(32'h10696671, 32'h12345678, 4'b1100);
    chk("nor", Output, 32'hED828986);
    run_op(32'h80000000, 32'h00000001, 4'b0111);
    chk("slt_neg", Output, 1);
    run_op(32'h7FFFFFFF, 32'hFFFFFFFF, 4'b0111);
    chk("slt_ovf", Output, 0); chk("slt_ovf_zero", Zero_Flag, 1);
    run_op(32'hFFFFFFFF, 32'h00000001, 4'b0010);
    chk("add_wrap", Output, 0); chk("add_wrap_zero", Zero_Flag, 1);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1000);
    chk("mult_hi", Hi, 32'hFFFFFFFE); chk("mult_lo", Lo, 1); chk("mult_out", Output, 1);
    chk("mult_lat", lat, 33); chk("mult_busy", busy_n, 33); chk("mult_zero", Zero_Flag, 0);
    run_op(32'h00000003, 32'h00000005, 4'b0000);
    chk("and_keep_hi", Hi, 32'hFFFFFFFE); chk("and_keep_lo", Lo, 1); chk("and_small", Output, 1);
    run_op(32'd100, 32'd7, 4'b1001);
    chk("divu_q", Lo, 14); chk("divu_r", Hi, 2); chk("divu_lat", lat, 33);
    run_op(32'd1, 32'd1, 4'b1111);
    chk("bad_out", Output, 0); chk("bad_err", Error, 1); chk("bad_zero", Zero_Flag, 1);
    chk("bad_keep_lo", Lo, 14);
    run_op(32'd5, 32'd0, 4'b1001);
    chk("div0_q", Lo, 32'hFFFFFFFF); chk("div0_r", Hi, 5); chk("div0_err", Error, 0);
    chk("div0_lat", lat, 33);
    // a second Start mid-MULT must not disturb the captured operands
    @(posedge clk); #1;
    A = 3; B = 5; ALU_Ctl = 4'b1000; Start = 1;
    @(posedge clk); #1;
    Start = 0; lat = 1;
    repeat (5) begin @(posedge clk); #1; lat++; end
    A = 7; B = 9; ALU_Ctl = 4'b0000; Start = 1;
    @(posedge clk); #1;
    Start = 0; lat++;
    while (!Done && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("ign_lo", Lo, 15); chk("ign_hi", Hi, 0); chk("ign_out", Output, 15); chk("ign_lat", lat, 33);
    @(posedge clk); #1;
    chk("ign_idle", Busy, 0); chk("ign_nodone", Done, 0);
`ifdef ALU_OVERFLOW_EN
    run_op(32'h7FFFFFFF, 32'h00000001, 4'b0010);
    chk("ovf_add_out", Output, 32'h80000000); chk("ovf_add", Overflow, 1);
    run_op(32'h80000000, 32'h00000001, 4'b0110);
    chk("ovf_sub_out", Output, 32'h7FFFFFFF); chk("ovf_sub", Overflow, 1);
    run_op(32'h7FFFFFFF, 32'h00000001, 4'b0000);
    chk("ovf_and", Overflow, 0);
    run_op(32'd5, 32'd0, 4'b1001);
`endif
    @(posedge clk); #1;
    A = 100; B = 7; ALU_Ctl = 4'b1001; Start = 1;
    @(posedge clk); #1;
    Start = 0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1;
    @(posedge clk); #1;
    chk_reset_vals("abort");
    reset = 0;
    dones = 0;
    repeat (40) begin @(posedge clk); #1; if (Done) dones++; end
    chk("abort_nodone", dones, 0);
    run_op(32'd100, 32'd7, 4'b1001);
    chk("post_q", Lo, 14); chk("post_r", Hi, 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
